// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   SZ_*     funct3 access-size codes (B, H, W, BU, HU)
//   state_t  responder FSM state encoding {IDLE, WAIT, RESP}
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane steering for one data-memory access.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   : misaligned half/word accesses are flagged as errors
//   undefined : low address bits are ignored (natural alignment), so a
//               misaligned access silently targets the aligned lane
//
// Ports:
//   i_size      funct3 size/extension code
//   i_addr_lo   byte address bits [1:0]
//   i_we        1 = store, 0 = load
//   i_wdata     right-aligned store data
//   i_old_word  current RAM word (merge source for sub-word stores)
//   i_rd_word   RAM word used for load extraction
//   o_be        byte-enable mask; zero for loads and for errored requests
//   o_wword     merged word to write back
//   o_rdata     extended load data; zero for stores and errors
//   o_err       request is illegal (or misaligned when the macro is defined)
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic        w_legal;
    logic [3:0]  w_lanes;
    logic [31:0] w_new;
    logic [31:0] w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half lane is chosen by addr[1] alone, which is what gives the
    // natural-alignment masking when misalignment is not an error.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rd_word[7:0];
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            default: w_byte = i_rd_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    end

    always_comb begin
        w_legal = 1'b0;
        w_lanes = 4'b0000;
        w_new   = i_wdata;
        w_ext   = 32'd0;
        case (i_size)
            SZ_B: begin
                w_legal = 1'b1;
                w_lanes = 4'b0001 << i_addr_lo;
                w_new   = {4{i_wdata[7:0]}};
                w_ext   = {{24{w_byte[7]}}, w_byte};
            end
            SZ_BU: begin
                w_legal = !i_we;
                w_ext   = {24'd0, w_byte};
            end
            SZ_H: begin
                w_legal = 1'b1;
                w_lanes = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_new   = {2{i_wdata[15:0]}};
                w_ext   = {{16{w_half[15]}}, w_half};
            end
            SZ_HU: begin
                w_legal = !i_we;
                w_ext   = {16'd0, w_half};
            end
            SZ_W: begin
                w_legal = 1'b1;
                w_lanes = 4'b1111;
                w_ext   = i_rd_word;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic w_misalign;
    assign w_misalign = (((i_size == SZ_H) || (i_size == SZ_HU)) && i_addr_lo[0])
                     || ((i_size == SZ_W) && (i_addr_lo != 2'd0));
    assign o_err = !w_legal || w_misalign;
`else
    assign o_err = !w_legal;
`endif

    always_comb begin
        o_be = (i_we && !o_err) ? w_lanes : 4'b0000;
        for (int b = 0; b < 4; b++) begin
            o_wword[8*b +: 8] = o_be[b] ? w_new[8*b +: 8] : i_old_word[8*b +: 8];
        end
        o_rdata = (o_err || i_we) ? 32'd0 : w_ext;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port.
// One request at a time: accept, wait WAIT_CYCLES, access RAM, respond.
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN (see dmem_lane_unit)
//
// Parameters:
//   ADDR_W       byte-address width; RAM holds 2^(ADDR_W-2) words
//   WAIT_CYCLES  extra cycles between acceptance and access (0..15)
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_req_valid / o_req_ready request handshake
//   i_req_we, i_req_size      store flag, funct3 size code
//   i_req_addr, i_req_wdata   byte address, right-aligned store data
//   o_rsp_valid / i_rsp_ready response handshake
//   o_rsp_rdata, o_rsp_err    extended load data, error flag
//   o_dbg_state               current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid (and payload) until the transfer; o_rsp_valid,
// o_rsp_rdata and o_rsp_err stay stable until the response transfers.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_size,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output state_t            o_dbg_state
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_go;
    logic              w_acc_we;
    logic [2:0]        w_acc_size;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [ADDR_W-3:0] w_word_idx;
    logic [31:0]       w_old_word;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_rdata;
    logic              w_err;

    assign o_req_ready = (r_state == IDLE) && i_reset_n;
    assign w_accept    = i_req_valid && o_req_ready;

    // With no wait states the access happens on the acceptance edge, so it
    // must use the live request fields instead of the latched copy.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign w_acc_we    = i_req_we;
            assign w_acc_size  = i_req_size;
            assign w_acc_addr  = i_req_addr;
            assign w_acc_wdata = i_req_wdata;
        end else begin : g_latched
            assign w_acc_we    = r_we;
            assign w_acc_size  = r_size;
            assign w_acc_addr  = r_addr;
            assign w_acc_wdata = r_wdata;
        end
    endgenerate

    // True on the edge that enters RESP.
    assign w_go = ((r_state == WAIT) && (r_cnt == 4'd0))
               || ((WAIT_CYCLES == 0) && (r_state == IDLE) && w_accept);

    assign w_word_idx = w_acc_addr[ADDR_W-1:2];
    assign w_old_word = r_mem[w_word_idx];

    dmem_lane_unit u_lane (
        .i_size     (w_acc_size),
        .i_addr_lo  (w_acc_addr[1:0]),
        .i_we       (w_acc_we),
        .i_wdata    (w_acc_wdata),
        .i_old_word (w_old_word),
        .i_rd_word  (w_old_word),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_err      (w_err)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= i_req_we;
                        r_size  <= i_req_size;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_go) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_rdata;
                r_rsp_err   <= w_err;
            end
        end
    end

    // RAM is not reset; a store is dropped if reset is low on its edge.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && w_go && (w_be != 4'b0000)) begin
            r_mem[w_word_idx] <= w_wword;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule
